// File: rtl/cache_mem_arbiter.sv
// Arbitrates ICache/DCache/uncached channels onto one bridge port, one transaction at a time.
// Grant is combinational in IDLE, mem_req follows next cycle; losers wait at level until IDLE returns.
module cache_mem_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ic_rd_req,
   input  logic [31:0]  ic_rd_addr,
   input  logic         dc_rd_req,
   input  logic [31:0]  dc_rd_addr,
   input  logic         uc_rd_req,
   input  logic [31:0]  uc_rd_addr,
   input  logic [1:0]   uc_load_size,
   input  logic         dc_wr_req,
   input  logic [31:0]  dc_wr_addr,
   input  logic [127:0] dc_wr_data,
   input  logic         uc_wr_req,
   input  logic [31:0]  uc_wr_addr,
   input  logic [31:0]  uc_wr_data,
   input  logic [3:0]   uc_wr_wstrb,
   output logic         ic_rd_rdy,
   output logic         dc_rd_rdy,
   output logic         uc_rd_rdy,
   output logic         dc_wr_rdy,
   output logic         uc_wr_rdy,
   output logic         ic_ret_valid,
   output logic         dc_ret_valid,
   output logic         uc_ret_valid,
   output logic [127:0] ic_ret_data,
   output logic [127:0] dc_ret_data,
   output logic [31:0]  uc_ret_data,
   output logic         dc_wr_valid,
   output logic         uc_wr_valid,
   output logic         mem_req,
   output logic         mem_we,
   output logic         mem_line,
   output logic [31:0]  mem_addr,
   output logic [1:0]   mem_size,
   output logic [3:0]   mem_wstrb,
   output logic [127:0] mem_wdata,
   input  logic         mem_ack,
   input  logic         mem_done,
   input  logic [127:0] mem_rdata
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;
   typedef enum logic [2:0] {OWN_IC, OWN_DCR, OWN_UCR, OWN_DCW, OWN_UCW} owner_t;

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   state_t         r_state, w_state_nxt;
   owner_t         r_owner, w_owner;
   logic           w_any_req, w_grant, w_capture;
   logic [3:0]     r_starve_cnt;
   logic           r_mem_we, r_mem_line;
   logic [31:0]    r_mem_addr;
   logic [1:0]     r_mem_size;
   logic [3:0]     r_mem_wstrb;
   logic [127:0]   r_mem_wdata, r_ic_ret_data, r_dc_ret_data;
   logic [31:0]    r_uc_ret_data;

   // The starvation override sits above the fixed data-side priority chain.
   always_comb begin
      w_owner = OWN_IC;
      if (ic_rd_req && r_starve_cnt == LIMIT) w_owner = OWN_IC;
      else if (dc_wr_req)                     w_owner = OWN_DCW;
      else if (uc_wr_req)                     w_owner = OWN_UCW;
      else if (uc_rd_req)                     w_owner = OWN_UCR;
      else if (dc_rd_req)                     w_owner = OWN_DCR;
   end

   assign w_any_req = ic_rd_req | dc_rd_req | uc_rd_req | dc_wr_req | uc_wr_req;
   assign w_grant   = (r_state == S_IDLE) && !rst && w_any_req;
   assign w_capture = ((r_state == S_REQ) && mem_ack && mem_done) ||
                      ((r_state == S_WAIT) && mem_done);

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt  = r_state;
      ic_rd_rdy    = 1'b0;
      dc_rd_rdy    = 1'b0;
      uc_rd_rdy    = 1'b0;
      dc_wr_rdy    = 1'b0;
      uc_wr_rdy    = 1'b0;
      ic_ret_valid = 1'b0;
      dc_ret_valid = 1'b0;
      uc_ret_valid = 1'b0;
      dc_wr_valid  = 1'b0;
      uc_wr_valid  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_grant) begin
               w_state_nxt = S_REQ;
               ic_rd_rdy   = (w_owner == OWN_IC);
               dc_rd_rdy   = (w_owner == OWN_DCR);
               uc_rd_rdy   = (w_owner == OWN_UCR);
               dc_wr_rdy   = (w_owner == OWN_DCW);
               uc_wr_rdy   = (w_owner == OWN_UCW);
            end
         end
         S_REQ:  if (mem_ack) w_state_nxt = mem_done ? S_RESP : S_WAIT;
         S_WAIT: if (mem_done) w_state_nxt = S_RESP;
         S_RESP: begin
            w_state_nxt  = S_IDLE;
            ic_ret_valid = (r_owner == OWN_IC);
            dc_ret_valid = (r_owner == OWN_DCR);
            uc_ret_valid = (r_owner == OWN_UCR);
            dc_wr_valid  = (r_owner == OWN_DCW);
            uc_wr_valid  = (r_owner == OWN_UCW);
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_owner       <= OWN_IC;
         r_starve_cnt  <= 4'd0;
         r_mem_we      <= 1'b0;
         r_mem_line    <= 1'b0;
         r_mem_addr    <= 32'd0;
         r_mem_size    <= 2'd0;
         r_mem_wstrb   <= 4'd0;
         r_mem_wdata   <= 128'd0;
         r_ic_ret_data <= 128'd0;
         r_dc_ret_data <= 128'd0;
         r_uc_ret_data <= 32'd0;
      end else begin
         if (w_grant) begin
            r_owner     <= w_owner;
            r_mem_we    <= 1'b0;
            r_mem_line  <= 1'b1;
            r_mem_size  <= 2'd2;
            r_mem_wstrb <= 4'hF;
            r_mem_wdata <= 128'd0;
            case (w_owner)
               OWN_IC:  r_mem_addr <= ic_rd_addr;
               OWN_DCR: r_mem_addr <= dc_rd_addr;
               OWN_DCW: begin
                  r_mem_we    <= 1'b1;
                  r_mem_addr  <= dc_wr_addr;
                  r_mem_wdata <= dc_wr_data;
               end
               OWN_UCR: begin
                  r_mem_line  <= 1'b0;
                  r_mem_addr  <= uc_rd_addr;
                  r_mem_size  <= uc_load_size;
                  r_mem_wstrb <= 4'h0;
               end
               default: begin
                  r_mem_we    <= 1'b1;
                  r_mem_line  <= 1'b0;
                  r_mem_addr  <= uc_wr_addr;
                  r_mem_wstrb <= uc_wr_wstrb;
                  r_mem_wdata <= {96'd0, uc_wr_data};
               end
            endcase
         end
         // Only data-side grants that bypass a waiting ICache count toward starvation.
         if (r_state == S_IDLE) begin
            if (!ic_rd_req)
               r_starve_cnt <= 4'd0;
            else if (w_grant) begin
               if (w_owner == OWN_IC)        r_starve_cnt <= 4'd0;
               else if (r_starve_cnt != LIMIT) r_starve_cnt <= r_starve_cnt + 4'd1;
            end
         end
         if (w_capture) begin
            case (r_owner)
               OWN_IC:  r_ic_ret_data <= mem_rdata;
               OWN_DCR: r_dc_ret_data <= mem_rdata;
               OWN_UCR: r_uc_ret_data <= mem_rdata[31:0];
               default: ;
            endcase
         end
      end
   end

   assign mem_req     = (r_state == S_REQ);
   assign mem_we      = r_mem_we;
   assign mem_line    = r_mem_line;
   assign mem_addr    = r_mem_addr;
   assign mem_size    = r_mem_size;
   assign mem_wstrb   = r_mem_wstrb;
   assign mem_wdata   = r_mem_wdata;
   assign ic_ret_data = r_ic_ret_data;
   assign dc_ret_data = r_dc_ret_data;
   assign uc_ret_data = r_uc_ret_data;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: drives at negedge, samples 1ns later.
module tb_cache_mem_arbiter;

   logic         clk = 1'b0;
   logic         rst;
   logic         ic_rd_req, dc_rd_req, uc_rd_req, dc_wr_req, uc_wr_req;
   logic [31:0]  ic_rd_addr, dc_rd_addr, uc_rd_addr, dc_wr_addr, uc_wr_addr;
   logic [1:0]   uc_load_size;
   logic [127:0] dc_wr_data;
   logic [31:0]  uc_wr_data;
   logic [3:0]   uc_wr_wstrb;
   logic         ic_rd_rdy, dc_rd_rdy, uc_rd_rdy, dc_wr_rdy, uc_wr_rdy;
   logic         ic_ret_valid, dc_ret_valid, uc_ret_valid, dc_wr_valid, uc_wr_valid;
   logic [127:0] ic_ret_data, dc_ret_data;
   logic [31:0]  uc_ret_data;
   logic         mem_req, mem_we, mem_line, mem_ack, mem_done;
   logic [31:0]  mem_addr;
   logic [1:0]   mem_size;
   logic [3:0]   mem_wstrb;
   logic [127:0] mem_wdata, mem_rdata;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   cache_mem_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk(clk), .rst(rst),
      .ic_rd_req(ic_rd_req), .ic_rd_addr(ic_rd_addr),
      .dc_rd_req(dc_rd_req), .dc_rd_addr(dc_rd_addr),
      .uc_rd_req(uc_rd_req), .uc_rd_addr(uc_rd_addr), .uc_load_size(uc_load_size),
      .dc_wr_req(dc_wr_req), .dc_wr_addr(dc_wr_addr), .dc_wr_data(dc_wr_data),
      .uc_wr_req(uc_wr_req), .uc_wr_addr(uc_wr_addr), .uc_wr_data(uc_wr_data),
      .uc_wr_wstrb(uc_wr_wstrb),
      .ic_rd_rdy(ic_rd_rdy), .dc_rd_rdy(dc_rd_rdy), .uc_rd_rdy(uc_rd_rdy),
      .dc_wr_rdy(dc_wr_rdy), .uc_wr_rdy(uc_wr_rdy),
      .ic_ret_valid(ic_ret_valid), .dc_ret_valid(dc_ret_valid), .uc_ret_valid(uc_ret_valid),
      .ic_ret_data(ic_ret_data), .dc_ret_data(dc_ret_data), .uc_ret_data(uc_ret_data),
      .dc_wr_valid(dc_wr_valid), .uc_wr_valid(uc_wr_valid),
      .mem_req(mem_req), .mem_we(mem_we), .mem_line(mem_line), .mem_addr(mem_addr),
      .mem_size(mem_size), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_done(mem_done), .mem_rdata(mem_rdata)
   );

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      ic_rd_req = 0; dc_rd_req = 0; uc_rd_req = 0; dc_wr_req = 0; uc_wr_req = 0;
      ic_rd_addr = 0; dc_rd_addr = 0; uc_rd_addr = 0; dc_wr_addr = 0; uc_wr_addr = 0;
      uc_load_size = 0; dc_wr_data = 0; uc_wr_data = 0; uc_wr_wstrb = 0;
      mem_ack = 0; mem_done = 0; mem_rdata = 0;
      step(); step();
      rst = 1'b0;
      n_tests++;
      if ({mem_req, mem_we, mem_line, mem_size, mem_wstrb} !== 9'd0) begin
         n_fail++; $display("FAIL reset_ctrl got %b want 0", {mem_req, mem_we, mem_line, mem_size, mem_wstrb});
      end
      n_tests++;
      if ({mem_addr, mem_wdata, ic_ret_data, dc_ret_data, uc_ret_data} !== '0) begin
         n_fail++; $display("FAIL reset_data got addr %h wdata %h want 0", mem_addr, mem_wdata);
      end
      n_tests++;
      if ({ic_rd_rdy, dc_rd_rdy, uc_rd_rdy, dc_wr_rdy, uc_wr_rdy, ic_ret_valid, dc_ret_valid,
           uc_ret_valid, dc_wr_valid, uc_wr_valid} !== 10'd0) begin
         n_fail++; $display("FAIL reset_pulses got nonzero want 0");
      end
   endtask

   task automatic test_ic_read();
      step();
      ic_rd_req = 1; ic_rd_addr = 32'h1FC0_0000;
      #1;
      n_tests++;
      if ({ic_rd_rdy, dc_rd_rdy, uc_rd_rdy, dc_wr_rdy, uc_wr_rdy} !== 5'b10000) begin
         n_fail++; $display("FAIL ic_grant got %b want 10000", {ic_rd_rdy, dc_rd_rdy, uc_rd_rdy, dc_wr_rdy, uc_wr_rdy});
      end
      step();
      ic_rd_req = 0; ic_rd_addr = 32'hDEAD_BEEF;
      n_tests++;
      if ({mem_req, mem_we, mem_line, mem_size, mem_wstrb, mem_addr} !== {1'b1, 1'b0, 1'b1, 2'd2, 4'hF, 32'h1FC0_0000}) begin
         n_fail++; $display("FAIL ic_memreq got req %b line %b addr %h want 1 1 1fc00000", mem_req, mem_line, mem_addr);
      end
      mem_ack = 1;
      step();
      mem_ack = 0; mem_done = 1; mem_rdata = 128'h0123;
      n_tests++;
      if (mem_req !== 1'b0) begin
         n_fail++; $display("FAIL ic_req_drop got %b want 0", mem_req);
      end
      step();
      mem_done = 0; mem_rdata = 0;
      n_tests++;
      if ({ic_ret_valid, dc_ret_valid, uc_ret_valid} !== 3'b100 || ic_ret_data !== 128'h0123) begin
         n_fail++; $display("FAIL ic_ret got v %b data %h want 100 0123", {ic_ret_valid, dc_ret_valid, uc_ret_valid}, ic_ret_data);
      end
      step();
      n_tests++;
      if (ic_ret_valid !== 1'b0 || ic_ret_data !== 128'h0123) begin
         n_fail++; $display("FAIL ic_ret_hold got v %b data %h want 0 0123", ic_ret_valid, ic_ret_data);
      end
   endtask

   task automatic test_dc_order();
      dc_wr_req = 1; dc_wr_addr = 32'h0000_1000; dc_wr_data = 128'hAAAA_BBBB_CCCC_DDDD_1111_2222_3333_4444;
      dc_rd_req = 1; dc_rd_addr = 32'h0000_2000;
      #1;
      n_tests++;
      if ({dc_wr_rdy, dc_rd_rdy} !== 2'b10) begin
         n_fail++; $display("FAIL dc_prio got wr,rd %b want 10", {dc_wr_rdy, dc_rd_rdy});
      end
      step();
      dc_wr_req = 0;
      n_tests++;
      if ({mem_req, mem_we, mem_line, mem_addr} !== {1'b1, 1'b1, 1'b1, 32'h1000} ||
          mem_wdata !== 128'hAAAA_BBBB_CCCC_DDDD_1111_2222_3333_4444 || dc_rd_rdy !== 1'b0) begin
         n_fail++; $display("FAIL dc_wr_fields got we %b addr %h wdata %h want 1 1000 aaaa..4444", mem_we, mem_addr, mem_wdata);
      end
      mem_ack = 1;
      step();
      mem_ack = 0; mem_done = 1;
      step();
      mem_done = 0;
      n_tests++;
      if ({dc_wr_valid, dc_rd_rdy} !== 2'b10) begin
         n_fail++; $display("FAIL dc_wr_done got valid,rd_rdy %b want 10", {dc_wr_valid, dc_rd_rdy});
      end
      step();
      n_tests++;
      if (dc_rd_rdy !== 1'b1) begin
         n_fail++; $display("FAIL dc_rd_after got %b want 1", dc_rd_rdy);
      end
      step();
      dc_rd_req = 0;
      n_tests++;
      if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h2000}) begin
         n_fail++; $display("FAIL dc_rd_fields got we %b addr %h want 0 2000", mem_we, mem_addr);
      end
      mem_ack = 1; mem_done = 1; mem_rdata = 128'h5555_0000_6666;
      step();
      mem_ack = 0; mem_done = 0; mem_rdata = 0;
      n_tests++;
      if (dc_ret_valid !== 1'b1 || dc_ret_data !== 128'h5555_0000_6666) begin
         n_fail++; $display("FAIL dc_rd_ret got v %b data %h want 1 555500006666", dc_ret_valid, dc_ret_data);
      end
      step();
   endtask

   task automatic test_uc_read();
      uc_rd_req = 1; uc_rd_addr = 32'hBFAF_8001; uc_load_size = 2'd0;
      #1;
      n_tests++;
      if (uc_rd_rdy !== 1'b1) begin
         n_fail++; $display("FAIL uc_rd_grant got %b want 1", uc_rd_rdy);
      end
      step();
      uc_rd_req = 0; uc_load_size = 2'd3;
      n_tests++;
      if ({mem_req, mem_we, mem_line, mem_size, mem_addr} !== {1'b1, 1'b0, 1'b0, 2'd0, 32'hBFAF_8001}) begin
         n_fail++; $display("FAIL uc_rd_fields got line %b size %0d addr %h want 0 0 bfaf8001", mem_line, mem_size, mem_addr);
      end
      mem_ack = 1;
      step();
      mem_ack = 0; mem_done = 1; mem_rdata = {96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 32'h0000_00AB};
      step();
      mem_done = 0; mem_rdata = 0;
      n_tests++;
      if (uc_ret_valid !== 1'b1 || uc_ret_data !== 32'h0000_00AB) begin
         n_fail++; $display("FAIL uc_rd_ret got v %b data %h want 1 000000ab", uc_ret_valid, uc_ret_data);
      end
      step();
   endtask

   task automatic test_uc_write();
      uc_wr_req = 1; uc_wr_addr = 32'hBFD0_0010; uc_wr_data = 32'h0000_1234; uc_wr_wstrb = 4'b0011;
      #1;
      n_tests++;
      if (uc_wr_rdy !== 1'b1) begin
         n_fail++; $display("FAIL uc_wr_grant got %b want 1", uc_wr_rdy);
      end
      step();
      uc_wr_req = 0; uc_wr_data = 32'hFFFF_FFFF; uc_wr_wstrb = 4'hF;
      n_tests++;
      if ({mem_we, mem_line, mem_size, mem_wstrb, mem_addr} !== {1'b1, 1'b0, 2'd2, 4'b0011, 32'hBFD0_0010} ||
          mem_wdata !== 128'h1234) begin
         n_fail++; $display("FAIL uc_wr_fields got wstrb %b wdata %h want 0011 1234", mem_wstrb, mem_wdata);
      end
      mem_ack = 1;
      step();
      mem_ack = 0; mem_done = 1;
      step();
      mem_done = 0;
      n_tests++;
      if ({uc_wr_valid, dc_wr_valid} !== 2'b10) begin
         n_fail++; $display("FAIL uc_wr_done got %b want 10", {uc_wr_valid, dc_wr_valid});
      end
      step();
   endtask

   task automatic test_starve();
      int dc_grants = 0;
      int ic_at = 0;
      ic_rd_req = 1; ic_rd_addr = 32'h1FC0_0040;
      dc_rd_req = 1; dc_rd_addr = 32'h0000_3000;
      for (int cyc = 0; cyc < 100 && ic_at == 0; cyc++) begin
         if (cyc != 0) step();
         #1;
         mem_ack = 0; mem_done = 0;
         if (mem_req) begin mem_ack = 1; mem_done = 1; end
         if (ic_rd_rdy) ic_at = dc_grants + 1;
         else if (dc_rd_rdy) dc_grants++;
      end
      n_tests++;
      if (ic_at !== 5) begin
         n_fail++; $display("FAIL starve_ic_arb got %0d want 5", ic_at);
      end
      step();
      ic_rd_req = 0; dc_rd_req = 0;
      for (int cyc = 0; cyc < 6; cyc++) begin
         mem_ack = 0; mem_done = 0;
         if (mem_req) begin mem_ack = 1; mem_done = 1; end
         step();
      end
      mem_ack = 0; mem_done = 0;
   endtask

   task automatic test_reset_mid();
      ic_rd_req = 1; ic_rd_addr = 32'h1FC0_0080;
      step();
      ic_rd_req = 0;
      mem_ack = 1;
      step();
      mem_ack = 0;
      rst = 1;
      step();
      rst = 0;
      n_tests++;
      if ({mem_req, mem_we, mem_line, mem_addr} !== '0 || ic_ret_data !== 128'd0 || ic_ret_valid !== 1'b0) begin
         n_fail++; $display("FAIL rst_mid got req %b addr %h ic_data %h want 0", mem_req, mem_addr, ic_ret_data);
      end
      mem_done = 1; mem_rdata = 128'h9999;
      step();
      mem_done = 0;
      step();
      n_tests++;
      if ({ic_ret_valid, dc_ret_valid, uc_ret_valid} !== 3'b000 || ic_ret_data !== 128'd0 || mem_req !== 1'b0) begin
         n_fail++; $display("FAIL stray_done got v %b data %h want 000 0", {ic_ret_valid, dc_ret_valid, uc_ret_valid}, ic_ret_data);
      end
   endtask

   initial begin
      test_reset();
      test_ic_read();
      test_dc_order();
      test_uc_read();
      test_uc_write();
      test_starve();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Shares the single memory-side bridge port among the ICache line-read channel, the DCache line-read and line-write channels, and the uncached word read/write channels. Sits between the caches' AXI_Bus_Interface and AXI_UNCACHE_Interface master modports and the AXI bridge. Serialises the traffic to one outstanding transaction and routes each response back to its owner. Data-side requests win by priority, and a starvation counter guarantees instruction fetch forward progress.

## Interface

Parameters:
- STARVE_LIMIT, 4: consecutive data-side grants allowed while ic_rd_req is pending before the ICache is forced through. Range 1–15.

Ports (clk/rst: one clock; reset is synchronous and active-high):
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- ic_rd_req / dc_rd_req / uc_rd_req  in  1  read requests (level)
- ic_rd_addr / dc_rd_addr / uc_rd_addr  in  32  read addresses
- uc_load_size  in  2  uncached read size: 0 byte, 1 half, 2 word
- dc_wr_req / uc_wr_req  in  1  write requests (level)
- dc_wr_addr / uc_wr_addr  in  32  write addresses
- dc_wr_data  in  128  dirty line to write back
- uc_wr_data  in  32  uncached store data
- uc_wr_wstrb  in  4  uncached byte enables
- ic_rd_rdy, dc_rd_rdy, uc_rd_rdy, dc_wr_rdy, uc_wr_rdy  out  1  one-cycle grant/accept pulses
- ic_ret_valid, dc_ret_valid, uc_ret_valid  out  1  one-cycle read-return pulses
- ic_ret_data, dc_ret_data  out  128  returned line
- uc_ret_data  out  32  returned word
- dc_wr_valid, uc_wr_valid  out  1  one-cycle write-complete pulses
- mem_req  out  1  transaction request to bridge
- mem_we  out  1  1 write, 0 read
- mem_line  out  1  1 four-word line burst, 0 single beat
- mem_addr  out  32  transaction address
- mem_size  out  2  beat size
- mem_wstrb  out  4  byte enables
- mem_wdata  out  128  write data
- mem_ack  in  1  bridge accepted mem_req this cycle
- mem_done  in  1  transaction complete; mem_rdata valid this cycle
- mem_rdata  in  128  read data. Uncached reads use [31:0].

## Operation

- FSM: IDLE → REQ → WAIT → RESP → IDLE.
- IDLE:
  - If any request is present, select a winner.
  - Assert the winner's *_rdy combinationally for that cycle.
  - Latch the owner id and all mem_* fields.
  - Go to REQ.
- Priority: dc_wr > uc_wr > uc_rd > dc_rd > ic_rd.
- Starvation override: the ICache wins regardless of priority when starve_cnt == STARVE_LIMIT and ic_rd_req = 1.
- starve_cnt:
  - Increments on each data-side grant made while ic_rd_req = 1, saturating at STARVE_LIMIT.
  - Clears on any ICache grant, or when ic_rd_req = 0 in IDLE.
- REQ: hold mem_req = 1 with stable fields until mem_ack. Then go to WAIT. If mem_done arrives in the same cycle as mem_ack, go directly to RESP.
- WAIT: on mem_done, register mem_rdata into the owner's ret_data and go to RESP.
- RESP: pulse the owner's ret_valid (reads) or wr_valid (writes) for one cycle. Go to IDLE.
- Field mapping:
  - Cache line reads: mem_line = 1, mem_size = 2, mem_wstrb = 4'hF.
  - DCache writes: same as line reads, plus mem_wdata = dc_wr_data.
  - Uncached reads: mem_line = 0, mem_size = uc_load_size.
  - Uncached writes: mem_line = 0, mem_size = 2, mem_wstrb = uc_wr_wstrb, mem_wdata = {96'b0, uc_wr_data}.
- A requester must hold req, address and data stable until it sees its rdy pulse. After that, its inputs are don't-care.
- Only one transaction is ever outstanding. DCache writeback-then-refill ordering is therefore preserved.

## Timing

- Reset: state IDLE, starve_cnt 0. Every output is 0: all rdy/valid pulses, mem_req, mem_we, mem_line, mem_addr, mem_size, mem_wstrb, mem_wdata, and all ret_data.
- Reset mid-transaction abandons it. mem_req is low in the cycle after rst is sampled. The bridge shares the same reset.
- Grant latency: rdy is asserted in the first IDLE cycle the request is seen. mem_req rises the next cycle (T+1).
- Minimum round trip: with mem_ack at T+1 and mem_done at T+2, ret_valid is at T+3. The next grant can occur at T+4.
- ret_data is registered and holds its value until the next response to the same owner.
- Requests arriving during REQ/WAIT/RESP get no rdy; they are evaluated on return to IDLE.
- mem_done without an outstanding transaction (state IDLE or REQ before ack) is ignored.

## Test plan

- Single ICache read, addr 0x1FC0_0000:
  - ic_rd_rdy at T.
  - mem_req = 1 with mem_line = 1, mem_addr = 0x1FC0_0000 at T+1.
  - ack T+1, done T+2 with rdata 0x…0123 → ic_ret_valid at T+3 with the same data.
- dc_wr_req and dc_rd_req asserted together → dc_wr granted first (mem_we = 1), dc_rd granted only after dc_wr_valid.
- Uncached byte read, uc_load_size = 0, addr 0xBFAF_8001 → mem_line = 0, mem_size = 0; mem_rdata[31:0] = 0xAB returned on uc_ret_data.
- Uncached store, wstrb 4'b0011, data 0x1234 → mem_wstrb = 4'b0011, mem_wdata = 0x…1234, uc_wr_valid pulse.
- Starvation, STARVE_LIMIT = 4: ic_rd_req held while dc_rd_req is re-asserted continuously → ICache granted on the fifth arbitration.
- rst asserted in WAIT:
  - Next cycle: all outputs 0 and state IDLE.
  - A later mem_done produces no ret_valid.
